// File: rtl/pn_infix_encoder_if.sv
// Token bus between infix source, encoder and PN evaluator.
// Latency: none, signal bundle only.
// Backpressure: in_ready throttles the infix side; the postfix side has none.
interface pn_infix_encoder_if;
    logic [1:0] mode;
    logic       in_valid;
    logic       in_last;
    logic       operator;
    logic [2:0] in;
    logic       in_ready;
    logic       out_valid;
    logic       out_last;
    logic [1:0] out_mode;
    logic       out_operator;
    logic [2:0] out_in;
    logic       err;

    modport slave (
        input  mode, in_valid, in_last, operator, in,
        output in_ready, out_valid, out_last, out_mode, out_operator, out_in, err
    );

    modport master (
        output mode, in_valid, in_last, operator, in,
        input  in_ready, out_valid, out_last, out_mode, out_operator, out_in, err
    );
endinterface

// File: rtl/pn_infix_encoder.sv
// Infix -> postfix token encoder (shunting-yard, 2-deep operator stack).
// Latency: operand emitted 1 cycle after acceptance; each stacked operator pop takes 1 cycle.
// Backpressure: in_ready drops while popping/flushing/erroring; output side never stalls.
module pn_infix_encoder #(
    parameter int MAX_TOKENS = 15,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pn_infix_encoder_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_POP,
        S_FLUSH,
        S_ERR
    } state_t;

    state_t           state, state_n;
    logic [1:0]       stk0, stk0_n;      // bottom of operator stack
    logic [1:0]       stk1, stk1_n;      // second entry (only used when sp == 2)
    logic [1:0]       sp, sp_n;          // number of stacked operators
    logic [1:0]       pend, pend_n;      // incoming operator waiting for pops to finish
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             expect_opnd, expect_opnd_n;
    logic [1:0]       mode_q, mode_n;
    logic             out_valid_q, out_valid_n;
    logic             out_last_q, out_last_n;
    logic             out_op_q, out_op_n;
    logic [2:0]       out_in_q, out_in_n;
    logic             err_q, err_n;

    logic             in_ready;
    logic             accept;
    logic             bad;
    logic [1:0]       top_op;
    logic [1:0]       in_op;

    // Binding strength: mul above add/sub.
    function automatic logic [1:0] prec(input logic [1:0] op);
        return (op == 2'd2) ? 2'd2 : 2'd1;
    endfunction

    // Next-state, stack update and registered-output values.
    always_comb begin
        state_n       = state;
        stk0_n        = stk0;
        stk1_n        = stk1;
        sp_n          = sp;
        pend_n        = pend;
        cnt_n         = cnt;
        expect_opnd_n = expect_opnd;
        mode_n        = mode_q;
        out_valid_n   = 1'b0;
        out_last_n    = 1'b0;
        out_op_n      = 1'b0;
        out_in_n      = 3'd0;
        err_n         = 1'b0;

        in_ready = (state == S_IDLE) || (state == S_ACCEPT);
        accept   = bus.in_valid && in_ready;
        top_op   = (sp == 2'd2) ? stk1 : stk0;
        in_op    = bus.in[1:0];
        // Grammar: operand/operator must alternate starting with an operand,
        // only an operand may close the expression, codes above 2 are illegal.
        bad = (bus.operator == expect_opnd)
            || (bus.operator && bus.in_last)
            || (bus.operator && (bus.in > 3'd2))
            || (cnt == CNT_W'(MAX_TOKENS));

        case (state)
            S_IDLE, S_ACCEPT: begin
                if (accept) begin
                    if (state == S_IDLE) begin
                        mode_n = bus.mode;
                    end
                    if (bad) begin
                        state_n       = S_ERR;
                        err_n         = 1'b1;
                        sp_n          = 2'd0;
                        cnt_n         = '0;
                        expect_opnd_n = 1'b1;
                    end else if (!bus.operator) begin
                        out_valid_n   = 1'b1;
                        out_in_n      = bus.in;
                        cnt_n         = cnt + CNT_W'(1);
                        expect_opnd_n = 1'b0;
                        state_n       = S_ACCEPT;
                        if (bus.in_last) begin
                            cnt_n         = '0;
                            expect_opnd_n = 1'b1;
                            if (sp == 2'd0) begin
                                out_last_n = 1'b1;
                                state_n    = S_IDLE;
                            end else begin
                                state_n = S_FLUSH;
                            end
                        end
                    end else begin
                        cnt_n         = cnt + CNT_W'(1);
                        expect_opnd_n = 1'b1;
                        state_n       = S_ACCEPT;
                        if ((sp != 2'd0) && (prec(top_op) >= prec(in_op))) begin
                            pend_n  = in_op;
                            state_n = S_POP;
                        end else if (sp == 2'd0) begin
                            stk0_n = in_op;
                            sp_n   = 2'd1;
                        end else begin
                            stk1_n = in_op;
                            sp_n   = 2'd2;
                        end
                    end
                end
            end
            S_POP: begin
                out_valid_n = 1'b1;
                out_op_n    = 1'b1;
                out_in_n    = {1'b0, top_op};
                // Pop again if the entry underneath still binds as tightly;
                // otherwise the pending operator takes the popped slot.
                if ((sp == 2'd2) && (prec(stk0) >= prec(pend))) begin
                    sp_n = 2'd1;
                end else if (sp == 2'd2) begin
                    stk1_n  = pend;
                    state_n = S_ACCEPT;
                end else begin
                    stk0_n  = pend;
                    sp_n    = 2'd1;
                    state_n = S_ACCEPT;
                end
            end
            S_FLUSH: begin
                out_valid_n = 1'b1;
                out_op_n    = 1'b1;
                out_in_n    = {1'b0, top_op};
                if (sp <= 2'd1) begin
                    out_last_n = 1'b1;
                    sp_n       = 2'd0;
                    state_n    = S_IDLE;
                end else begin
                    sp_n = sp - 2'd1;
                end
            end
            S_ERR: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                sp_n    = 2'd0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            stk0        <= 2'd0;
            stk1        <= 2'd0;
            sp          <= 2'd0;
            pend        <= 2'd0;
            cnt         <= '0;
            expect_opnd <= 1'b1;
            mode_q      <= 2'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_op_q    <= 1'b0;
            out_in_q    <= 3'd0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_n;
            stk0        <= stk0_n;
            stk1        <= stk1_n;
            sp          <= sp_n;
            pend        <= pend_n;
            cnt         <= cnt_n;
            expect_opnd <= expect_opnd_n;
            mode_q      <= mode_n;
            out_valid_q <= out_valid_n;
            out_last_q  <= out_last_n;
            out_op_q    <= out_op_n;
            out_in_q    <= out_in_n;
            err_q       <= err_n;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_last     = out_last_q;
    assign bus.out_mode     = mode_q;
    assign bus.out_operator = out_op_q;
    assign bus.out_in       = out_in_q;
    assign bus.err          = err_q;

endmodule
